// File: rtl/ctrl_cookie_filter.sv
// Control-packet cookie filter: forwards packets whose first-beat cookie matches c_val, drains the rest.
// Optional macro COOKIE_PREV_EN also accepts the cookie value that was live just before the latest change.
module ctrl_cookie_filter #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int COOKIE_LSB           = 224
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [31:0]                       c_val,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  input  logic                              s_axis_tlast,
  output logic                              s_axis_tready,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  output logic                              m_axis_tlast,
  input  logic                              m_axis_tready,
  output logic [31:0]                       pass_cnt,
  output logic [31:0]                       drop_cnt
);
  localparam int KW = C_S_AXIS_DATA_WIDTH/8;

  typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

  state_t                          state_q, state_d;
  logic [C_S_AXIS_DATA_WIDTH-1:0]  tdata_q;
  logic [KW-1:0]                   tkeep_q;
  logic [C_S_AXIS_TUSER_WIDTH-1:0] tuser_q;
  logic                            tvalid_q, tlast_q;
  logic [31:0]                     pass_cnt_q, drop_cnt_q;

  logic [31:0] field;
  logic        match, out_free, hs, load, pass_inc, drop_inc;

  assign field = s_axis_tdata[COOKIE_LSB +: 32];

`ifdef COOKIE_PREV_EN
  logic [31:0] c_last_q, c_prev_q;
  logic        prev_vld_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_last_q   <= 32'hf1ec234d;
      c_prev_q   <= 32'h0;
      prev_vld_q <= 1'b0;
    end else begin
      c_last_q <= c_val;
      if (c_val != c_last_q) begin
        c_prev_q   <= c_last_q;
        prev_vld_q <= 1'b1;
      end
    end
  end

  assign match = (field == c_val) | (prev_vld_q & (field == c_prev_q));
`else
  assign match = (field == c_val);
`endif

  assign out_free = ~tvalid_q | m_axis_tready;

  always_comb begin
    state_d       = state_q;
    s_axis_tready = 1'b0;
    hs            = 1'b0;
    load          = 1'b0;
    pass_inc      = 1'b0;
    drop_inc      = 1'b0;
    if (!rst) begin
      s_axis_tready = (state_q == DROP) ? 1'b1 : out_free;
      hs            = s_axis_tvalid & s_axis_tready;
      case (state_q)
        IDLE: if (hs) begin
          if (match) begin
            load     = 1'b1;
            pass_inc = 1'b1;
            state_d  = s_axis_tlast ? IDLE : PASS;
          end else begin
            drop_inc = 1'b1;
            state_d  = s_axis_tlast ? IDLE : DROP;
          end
        end
        PASS: if (hs) begin
          load = 1'b1;
          if (s_axis_tlast) state_d = IDLE;
        end
        DROP: if (hs && s_axis_tlast) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      tdata_q    <= '0;
      tkeep_q    <= '0;
      tuser_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      pass_cnt_q <= 32'h0;
      drop_cnt_q <= 32'h0;
    end else begin
      state_q <= state_d;
      if (load) begin
        tdata_q  <= s_axis_tdata;
        tkeep_q  <= s_axis_tkeep;
        tuser_q  <= s_axis_tuser;
        tlast_q  <= s_axis_tlast;
        tvalid_q <= 1'b1;
      end else if (m_axis_tready) begin
        tvalid_q <= 1'b0;
      end
      // Counts are taken at the first-beat verdict and stick at all-ones.
      if (pass_inc && pass_cnt_q != 32'hFFFFFFFF) pass_cnt_q <= pass_cnt_q + 32'd1;
      if (drop_inc && drop_cnt_q != 32'hFFFFFFFF) drop_cnt_q <= drop_cnt_q + 32'd1;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign pass_cnt      = pass_cnt_q;
  assign drop_cnt      = drop_cnt_q;
endmodule

// File: doc/ctrl_cookie_filter.md
# ctrl_cookie_filter

Authenticates reconfiguration (control) packets on the RMT control AXI-Stream path against the rolling cookie value `c_val`, which the cookie generator refreshes every 9 cycles. The cookie field of each control packet's first beat is compared against the live cookie; matching packets are forwarded through a one-stage register slice and mismatching packets are silently drained. The block sits between the control-packet parser and the stage configuration bus, directly downstream of the cookie generator.

## Interface
- `C_S_AXIS_DATA_WIDTH`, 256: tdata width in bits.
- `C_S_AXIS_TUSER_WIDTH`, 128: tuser width in bits, passed through unchanged.
- `COOKIE_LSB`, 224: bit offset of the 32-bit cookie field in first-beat tdata; the field is `tdata[COOKIE_LSB +: 32]`.
- `clk` input 1: the single clock.
- `rst` input 1: asynchronous, active-high reset.
- `c_val` input 32: current cookie from the cookie generator.
- `s_axis_tdata` input `C_S_AXIS_DATA_WIDTH`: incoming control beat data.
- `s_axis_tkeep` input `C_S_AXIS_DATA_WIDTH/8`: incoming byte enables.
- `s_axis_tuser` input `C_S_AXIS_TUSER_WIDTH`: incoming sideband.
- `s_axis_tvalid` input 1: incoming beat valid.
- `s_axis_tlast` input 1: incoming last beat of packet.
- `s_axis_tready` output 1: ready for incoming beat.
- `m_axis_tdata`, `m_axis_tkeep`, `m_axis_tuser`, `m_axis_tvalid`, `m_axis_tlast` output (widths as slave side): forwarded beat.
- `m_axis_tready` input 1: downstream ready.
- `pass_cnt` output 32: packets forwarded, saturating.
- `drop_cnt` output 32: packets dropped, saturating.

## Operation
- Definitions:
  - Handshake: `s_axis_tvalid & s_axis_tready`.
  - `out_free = ~m_axis_tvalid | m_axis_tready`.
- FSM states are `IDLE` (awaiting first beat), `PASS`, `DROP`; reset state is `IDLE`.
- `IDLE`:
  - `s_axis_tready = out_free`.
  - On handshake, evaluate `match` using that cycle's `c_val`.
  - If `match`: load the beat into the output register and increment `pass_cnt`. Next state is `IDLE` if tlast, else `PASS`.
  - If no `match`: discard the beat and increment `drop_cnt`. Next state is `IDLE` if tlast, else `DROP`.
- `PASS`:
  - `s_axis_tready = out_free`.
  - Each handshake loads the beat into the output register.
  - A tlast beat returns the FSM to `IDLE`.
- `DROP`:
  - `s_axis_tready = 1`; beats are discarded and the output register is untouched.
  - A tlast beat returns the FSM to `IDLE`.
- Output register:
  - Loads all fields when a beat is loaded, which sets `m_axis_tvalid`.
  - Clears `m_axis_tvalid` on `m_axis_tready` when no new beat is loaded that cycle.
  - Data is held stable while `m_axis_tvalid & ~m_axis_tready`.
- Counters saturate at `32'hFFFFFFFF`. The count is taken at first-beat decision, not at tlast.
- Single-beat packets (tlast on the first beat) are legal in both verdicts.
- `tkeep` is not inspected for the compare. A first beat with the cookie bytes unkept still compares raw tdata.

## Timing
- Reset values:
  - `m_axis_tvalid = 0`, `m_axis_tlast = 0`; tdata, tkeep and tuser are 0.
  - `pass_cnt = 0`, `drop_cnt = 0`; FSM is `IDLE`.
  - `s_axis_tready` is 0 while `rst` is high.
- Latency: an accepted beat appears on `m_axis` the next cycle.
- Full throughput: 1 beat/cycle while `m_axis_tready = 1`.
- Backpressure is combinational through `out_free`.
- `c_val` changing in the same cycle as a first-beat handshake: the compare uses the pre-edge (current) `c_val` value.
- Reset asserted mid-packet: the partial packet is abandoned and any pending output beat is lost. After reset, the next incoming beat is treated as a first beat and checked.

## Configuration
- `COOKIE_PREV_EN`: grace window for the previous cookie.
- Defined:
  - Register `c_last` tracks `c_val` every cycle; reset value `32'hf1ec234d`.
  - When `c_val != c_last`, capture `c_prev <= c_last` and set `prev_vld`.
  - `match = (field == c_val) | (prev_vld & field == c_prev)`.
  - `c_prev` and `prev_vld` reset to 0.
- Undefined: `match = (field == c_val)`; no extra registers.

## Test plan
- Single 3-beat packet, field = `c_val` = `32'hf1ec234d`, `m_axis_tready = 1`: 3 beats out, each 1 cycle late; `pass_cnt = 1`, `drop_cnt = 0`.
- 2-beat packet, field = `32'h12345678` ≠ `c_val`: no `m_axis_tvalid`, `s_axis_tready = 1` on beat 2, `drop_cnt = 1`.
- Matching 4-beat packet with `m_axis_tready` toggling 1/0 each cycle: all 4 beats out in order with no duplication, and data is stable during stalls.
- `COOKIE_PREV_EN` defined: `c_val` steps from `A` to `B`, then a packet carrying `A` passes and a packet carrying a value that is neither `A` nor `B` drops. Undefined: the packet carrying `A` drops.
- `rst` pulsed after beat 2 of a 5-beat matching packet: outputs return to reset values. Beats 3–5 are then re-checked as a new packet, and with field ≠ `c_val` they are dropped with `drop_cnt = 1`.
- Force `drop_cnt` to `32'hFFFFFFFE`, then send 3 mismatching single-beat packets: `drop_cnt` holds at `32'hFFFFFFFF`.
